gsim_b_feeder: RTL and testbench



---
 rtl/gsim_pkg.sv | 19 +
 rtl/gsim_b_bank.sv | 40 ++++
 rtl/gsim_b_feeder.sv | 162 ++++++++++++++++
 tb/tb_gsim_b_feeder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared constants and FSM state encoding for the GSIM b-vector feeder.
package gsim_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned BW    = 16;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned AW    = $clog2(N);

  typedef enum logic [1:0] {
    StFill    = 2'd0,
    StIssue   = 2'd1,
    StWaitRes = 2'd2
  } feed_state_e;

  function automatic logic is_last(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(N - 1);
  endfunction

endpackage

// File: rtl/gsim_b_bank.sv
// N x BW element buffer: in-order synchronous write, combinational read, full flag.
module gsim_b_bank
  import gsim_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [BW-1:0] wr_data,
  input  logic          clr,
  input  logic [AW-1:0] rptr,
  output logic [BW-1:0] rd_data,
  output logic          full,
  output logic          last_wr
);

  logic [CNT_W-1:0] wptr_q;
  logic [BW-1:0]    mem_q [N];
  logic             wr_ok;

  assign full    = (wptr_q == CNT_W'(N));
  assign wr_ok   = wr_en && !full;
  // Flags the write that completes the vector so the owner can react in the same cycle.
  assign last_wr = wr_ok && is_last(wptr_q);
  assign rd_data = mem_q[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr) begin
      wptr_q <= '0;
    end else if (wr_ok) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data;
      wptr_q                <= wptr_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gsim_b_feeder.sv
// Buffers host b-vectors and issues them as gap-free N-cycle bursts to the GSIM solver.
// Define GSIM_FEED_PINGPONG_EN for two banks so the next vector fills while one is in flight.
module gsim_b_feeder
  import gsim_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [BW-1:0] s_data,
  output logic          in_en,
  output logic [BW-1:0] b_in,
  input  logic          sol_out_valid,
  output logic          busy
);

  feed_state_e      state_q;
  logic [AW-1:0]    rptr_q;
  logic [CNT_W-1:0] rcnt_q;
  logic             s_ready_q;
  logic             in_en_q;
  logic             busy_q;
  logic [BW-1:0]    b_in_q;

  logic             accept;
  logic             done;
  logic             start_fill;
  logic             start_next;
  logic             s_ready_nx;
  logic [BW-1:0]    rd_data;

  assign accept = s_valid && s_ready_q;
  assign done   = (state_q == StWaitRes) && sol_out_valid && is_last(rcnt_q);

`ifdef GSIM_FEED_PINGPONG_EN
  logic       fill_sel_q;
  logic       iss_sel_q;
  logic       fill_sel_nx;
  logic [1:0] wr_en;
  logic [1:0] clr;
  logic [1:0] full;
  logic [1:0] last_wr;
  logic [1:0] full_nx;
  logic [BW-1:0] rd_a;
  logic [BW-1:0] rd_b;

  assign wr_en       = {accept && fill_sel_q, accept && !fill_sel_q};
  assign clr         = {done && iss_sel_q, done && !iss_sel_q};
  // Occupancy as it will be after this edge; lets issue and s_ready react without a bubble.
  assign full_nx     = ~clr & (full | last_wr);
  assign fill_sel_nx = fill_sel_q ^ (|last_wr);
  assign rd_data     = iss_sel_q ? rd_b : rd_a;
  assign start_fill  = full_nx[iss_sel_q];
  assign start_next  = full_nx[~iss_sel_q];
  assign s_ready_nx  = !full_nx[fill_sel_nx];

  gsim_b_bank u_bank_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en[0]),
    .wr_data (s_data),
    .clr     (clr[0]),
    .rptr    (rptr_q),
    .rd_data (rd_a),
    .full    (full[0]),
    .last_wr (last_wr[0])
  );

  gsim_b_bank u_bank_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en[1]),
    .wr_data (s_data),
    .clr     (clr[1]),
    .rptr    (rptr_q),
    .rd_data (rd_b),
    .full    (full[1]),
    .last_wr (last_wr[1])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_sel_q <= 1'b0;
      iss_sel_q  <= 1'b0;
    end else begin
      fill_sel_q <= fill_sel_nx;
      iss_sel_q  <= iss_sel_q ^ done;
    end
  end
`else
  logic full;
  logic last_wr;
  logic full_nx;

  assign full_nx    = !done && (full || last_wr);
  assign start_fill = full_nx;
  assign start_next = 1'b0;
  assign s_ready_nx = !full_nx;

  gsim_b_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_data (s_data),
    .clr     (done),
    .rptr    (rptr_q),
    .rd_data (rd_data),
    .full    (full),
    .last_wr (last_wr)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill;
      rptr_q    <= '0;
      rcnt_q    <= '0;
      s_ready_q <= 1'b0;
      in_en_q   <= 1'b0;
      b_in_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      s_ready_q <= s_ready_nx;
      unique case (state_q)
        StFill: begin
          in_en_q <= 1'b0;
          if (start_fill) begin
            state_q <= StIssue;
            rptr_q  <= '0;
          end
        end
        StIssue: begin
          in_en_q <= 1'b1;
          b_in_q  <= rd_data;
          busy_q  <= 1'b1;
          rptr_q  <= rptr_q + AW'(1);
          if (rptr_q == AW'(N - 1)) begin
            state_q <= StWaitRes;
          end
        end
        StWaitRes: begin
          in_en_q <= 1'b0;
          if (done) begin
            rcnt_q  <= '0;
            rptr_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= start_next ? StIssue : StFill;
          end else if (sol_out_valid) begin
            rcnt_q <= rcnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign in_en   = in_en_q;
  assign b_in    = b_in_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_gsim_b_feeder.sv
// Self-checking bench for gsim_b_feeder; each accepted vector must reappear as one 16-cycle burst.
module tb_gsim_b_feeder;

`ifdef GSIM_FEED_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  typedef logic [15:0] vec_t [16];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        in_en;
  logic [15:0] b_in;
  logic        sol_out_valid = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;

  // Burst capture: every in_en word, and the length of every contiguous in_en run.
  logic [15:0] got[$];
  int          runs[$];
  int          run_len = 0;

  gsim_b_feeder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .in_en         (in_en),
    .b_in          (b_in),
    .sol_out_valid (sol_out_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (in_en) begin
      got.push_back(b_in);
      run_len++;
    end else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  end

  task automatic send_vec(input vec_t v, input int mode, output int stalls);
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = (mode == 1 && i != 0) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      if (gap != 0) begin
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = v[i];
      for (int t = 0; t < 200 && !s_ready; t++) begin
        stalls++;
        @(negedge clk);
      end
      if (!s_ready) begin
        total++;
        bad++;
        $display("FAIL send_timeout elem=%0d s_ready=%b want=1", i, s_ready);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic drive_results(input int n, input bit gappy);
    for (int i = 0; i < n; i++) begin
      if (gappy) repeat ($urandom_range(0, 2)) @(negedge clk);
      sol_out_valid = 1'b1;
      @(negedge clk);
      sol_out_valid = 1'b0;
    end
  endtask

  task automatic wait_burst(input int base);
    for (int t = 0; t < 100 && runs.size() <= base; t++) @(negedge clk);
    total++;
    if (runs.size() <= base) begin
      bad++;
      $display("FAIL burst_timeout runs=%0d want>%0d", runs.size(), base);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
    total++; if (in_en !== 1'b0) begin bad++; $display("FAIL rst_in_en got=%b want=0", in_en); end
    total++; if (b_in !== 16'h0) begin bad++; $display("FAIL rst_b_in got=%h want=0000", b_in); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rel_s_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_basic();
    vec_t v;
    int   stalls, base, gb;
    for (int i = 0; i < 16; i++) v[i] = 16'(i + 1);
    base = runs.size();
    gb   = got.size();
    send_vec(v, 0, stalls);
    total++; if (stalls != 0) begin bad++; $display("FAIL basic_stalls got=%0d want=0", stalls); end
    total++; if (s_ready !== PP) begin bad++; $display("FAIL basic_ready_full got=%b want=%b", s_ready, PP); end
    total++; if (in_en !== 1'b0) begin bad++; $display("FAIL basic_issue_lat got=%b want=0", in_en); end
    @(negedge clk);
    total++;
    if (in_en !== 1'b1 || b_in !== v[0]) begin
      bad++; $display("FAIL basic_first in_en=%b b_in=%h want=1/%h", in_en, b_in, v[0]);
    end
    wait_burst(base);
    total++; if (runs[base] != 16) begin bad++; $display("FAIL basic_len got=%0d want=16", runs[base]); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (got[gb+i] !== v[i]) begin bad++; $display("FAIL basic_data[%0d] got=%h want=%h", i, got[gb+i], v[i]); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
  endtask

  task automatic test_results();
    drive_results(15, 1'b1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL res15_busy got=%b want=1", busy); end
    total++; if (s_ready !== PP) begin bad++; $display("FAIL res15_ready got=%b want=%b", s_ready, PP); end
    drive_results(1, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL res16_busy got=%b want=0", busy); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL res16_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_toggle();
    vec_t v;
    int   stalls, base, gb;
    for (int i = 0; i < 16; i++) v[i] = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
    base = runs.size();
    gb   = got.size();
    send_vec(v, 1, stalls);
    wait_burst(base);
    total++; if (runs[base] != 16) begin bad++; $display("FAIL toggle_len got=%0d want=16", runs[base]); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (got[gb+i] !== v[i]) begin bad++; $display("FAIL toggle_data[%0d] got=%h want=%h", i, got[gb+i], v[i]); end
    end
    drive_results(16, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL toggle_busy got=%b want=0", busy); end
  endtask

  task automatic test_ignore();
    vec_t v;
    int   stalls, base, gb;
    repeat (3) begin
      sol_out_valid = 1'b1;
      @(negedge clk);
      sol_out_valid = 1'b0;
      @(negedge clk);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy_fill got=%b want=0", busy); end
    for (int i = 0; i < 16; i++) v[i] = 16'($urandom);
    base = runs.size();
    gb   = got.size();
    send_vec(v, 2, stalls);
    wait_burst(base);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (got[gb+i] !== v[i]) begin bad++; $display("FAIL ign_data[%0d] got=%h want=%h", i, got[gb+i], v[i]); end
    end
    drive_results(15, 1'b1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy15 got=%b want=1", busy); end
    drive_results(1, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy16 got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    vec_t v, w;
    int   stalls, cnt, base, gb;
    for (int i = 0; i < 16; i++) begin
      v[i] = 16'($urandom);
      w[i] = 16'($urandom);
    end
    send_vec(v, 0, stalls);
    cnt = 0;
    for (int t = 0; t < 100 && cnt < 8; t++) begin
      @(negedge clk);
      if (in_en) cnt++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (in_en !== 1'b0) begin bad++; $display("FAIL mid_in_en got=%b want=0", in_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b want=0", s_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%b want=1", s_ready); end
    base = runs.size();
    gb   = got.size();
    send_vec(w, 0, stalls);
    wait_burst(base);
    total++; if (runs[base] != 16) begin bad++; $display("FAIL mid_len got=%0d want=16", runs[base]); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (got[gb+i] !== w[i]) begin bad++; $display("FAIL mid_data[%0d] got=%h want=%h", i, got[gb+i], w[i]); end
    end
    drive_results(16, 1'b1);
  endtask

  task automatic test_random();
    vec_t v;
    int   stalls, base, gb;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 16; i++) v[i] = 16'($urandom);
      base = runs.size();
      gb   = got.size();
      send_vec(v, 2, stalls);
      wait_burst(base);
      total++; if (runs[base] != 16) begin bad++; $display("FAIL rnd_len got=%0d want=16", runs[base]); end
      for (int i = 0; i < 16; i++) begin
        total++;
        if (got[gb+i] !== v[i]) begin bad++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, got[gb+i], v[i]); end
      end
      drive_results(16, 1'b1);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_busy got=%b want=0", busy); end
    end
  endtask

`ifdef GSIM_FEED_PINGPONG_EN
  task automatic test_pingpong();
    vec_t v1, v2;
    int   stalls, base, gb;
    for (int i = 0; i < 16; i++) begin
      v1[i] = 16'($urandom);
      v2[i] = 16'($urandom);
    end
    base = runs.size();
    gb   = got.size();
    send_vec(v1, 0, stalls);
    wait_burst(base);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL pp_ready_wait got=%b want=1", s_ready); end
    send_vec(v2, 2, stalls);
    total++; if (runs.size() != base + 1 || in_en !== 1'b0) begin
      bad++; $display("FAIL pp_early_issue runs=%0d in_en=%b want=%0d/0", runs.size(), in_en, base + 1);
    end
    drive_results(16, 1'b1);
    total++; if (in_en !== 1'b0) begin bad++; $display("FAIL pp_issue_lat got=%b want=0", in_en); end
    @(negedge clk);
    total++;
    if (in_en !== 1'b1 || b_in !== v2[0]) begin
      bad++; $display("FAIL pp_first in_en=%b b_in=%h want=1/%h", in_en, b_in, v2[0]);
    end
    wait_burst(base + 1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (got[gb+i] !== v1[i]) begin bad++; $display("FAIL pp_v1[%0d] got=%h want=%h", i, got[gb+i], v1[i]); end
      total++;
      if (got[gb+16+i] !== v2[i]) begin bad++; $display("FAIL pp_v2[%0d] got=%h want=%h", i, got[gb+16+i], v2[i]); end
    end
    drive_results(16, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pp_busy got=%b want=0", busy); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_results();
    test_toggle();
    test_ignore();
    test_reset_mid();
    test_random();
`ifdef GSIM_FEED_PINGPONG_EN
    test_pingpong();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
